// File: rtl/sequencer.sv
// Moore control sequencer for the 8-bit accumulator processor: walks fetch/decode/execute
// and drives every sysbus, register-load and memory strobe from the current state.
module sequencer #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3,
   parameter int CNT_W  = 8
) (
   input  logic             clock,
   input  logic             n_reset,
   input  logic [OP_W-1:0]  op,
   input  logic             z_flag,
   output logic             PC_bus,
   output logic             Addr_bus,
   output logic             ACC_bus,
   output logic             MDR_bus,
   output logic             load_MAR,
   output logic             load_MDR,
   output logic             CS,
   output logic             R_NW,
   output logic             load_IR,
   output logic             load_PC,
   output logic             INC_PC,
   output logic             load_ACC,
   output logic [1:0]       alu_op,
   output logic [CNT_W-1:0] instr_count
);

   // The opcode field lives in the top bits of the IR word, so it can never be wider.
   if (OP_W > WORD_W) begin : g_bad_op_w
      $error("sequencer: OP_W must not exceed WORD_W");
   end

   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F0   = 3'd1,
      S_F1   = 3'd2,
      S_D0   = 3'd3,
      S_XRD  = 3'd4,
      S_XST  = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [OP_W-1:0]  r_op;
   logic [CNT_W-1:0] r_count;
   logic             w_retire;

   // An instruction retires whenever execution returns to fetch; the reset exit is not one.
   assign w_retire    = (w_next == S_F0) &&
                        (r_state == S_D0 || r_state == S_XRD || r_state == S_XST);
   assign instr_count = r_count;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_D0) r_op <= op;
         if (w_retire) r_count <= r_count + CNT_W'(1);
      end
   end

   always_comb begin
      w_next   = r_state;
      PC_bus   = 1'b0;
      Addr_bus = 1'b0;
      ACC_bus  = 1'b0;
      MDR_bus  = 1'b0;
      load_MAR = 1'b0;
      load_MDR = 1'b0;
      CS       = 1'b0;
      R_NW     = 1'b1;
      load_IR  = 1'b0;
      load_PC  = 1'b0;
      INC_PC   = 1'b0;
      load_ACC = 1'b0;
      alu_op   = 2'b00;
      case (r_state)
         S_IDLE: w_next = S_F0;
         S_F0: begin
            PC_bus   = 1'b1;
            load_MAR = 1'b1;
            load_PC  = 1'b1;
            INC_PC   = 1'b1;
            w_next   = S_F1;
         end
         S_F1: begin
            CS      = 1'b1;
            MDR_bus = 1'b1;
            load_IR = 1'b1;
            w_next  = S_D0;
         end
         S_D0: begin
            Addr_bus = 1'b1;
            load_MAR = 1'b1;
            // op is the IR field loaded on the F1 edge; z_flag matters only here.
            if (op == OP_STORE)
               w_next = S_XST;
            else if (op == OP_BNE)
               w_next = z_flag ? S_F0 : S_XRD;
            else if (op == OP_LOAD || op == OP_ADD || op == OP_SUB || op == OP_XOR)
               w_next = S_XRD;
            else
               w_next = S_F0;
         end
         S_XRD: begin
            CS      = 1'b1;
            MDR_bus = 1'b1;
            w_next  = S_F0;
            case (r_op)
               OP_LOAD: begin load_ACC = 1'b1; alu_op = 2'b00; end
               OP_ADD:  begin load_ACC = 1'b1; alu_op = 2'b01; end
               OP_SUB:  begin load_ACC = 1'b1; alu_op = 2'b10; end
               OP_XOR:  begin load_ACC = 1'b1; alu_op = 2'b11; end
               OP_BNE:  load_PC = 1'b1;
               default: ;
            endcase
         end
         S_XST: begin
            ACC_bus  = 1'b1;
            load_MDR = 1'b1;
            CS       = 1'b1;
            R_NW     = 1'b0;
            w_next   = S_F0;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Moore control unit for the basic 8-bit accumulator processor.
- Sits directly upstream of the memory-mapped ROM/RAM and of the PC, IR, ACC and ALU datapath registers.
- Generates every bus-drive, register-load and chip-select strobe that moves words over the shared tri-state sysbus.
- Sequences fetch / decode / execute from the IR opcode and the ACC zero flag.

Parameters:
WORD_W, 8, system bus and data word width
OP_W, 3, opcode field width (IR[WORD_W-1 -: OP_W])
CNT_W, 8, width of the retired-instruction counter

Ports:
clock  in  1  system clock, all state updates on its rising edge
n_reset  in  1  asynchronous active-low reset
op  in  OP_W  opcode field of the IR
z_flag  in  1  1 when ACC == 0
PC_bus  out  1  PC drives sysbus
Addr_bus  out  1  IR operand field drives sysbus (zero-extended)
ACC_bus  out  1  ACC drives sysbus
MDR_bus  out  1  selected memory drives sysbus
load_MAR  out  1  memory MAR captures sysbus address bits
load_MDR  out  1  memory MDR captures sysbus
CS  out  1  memory chip select
R_NW  out  1  1 = read, 0 = write (qualified by CS)
load_IR  out  1  IR captures sysbus
load_PC  out  1  PC captures next value
INC_PC  out  1  PC next value = PC+1 (else sysbus)
load_ACC  out  1  ACC captures ALU result
alu_op  out  2  00 pass sysbus, 01 ACC+bus, 10 ACC-bus, 11 ACC^bus
instr_count  out  CNT_W  instructions retired since reset

Behaviour:
- Opcode encoding is fixed:
  - LOAD=000, STORE=001, ADD=010, SUB=011, BNE=100, XOR=101.
  - 110 and 111 execute as NOP.
- States: IDLE, F0, F1, D0, XRD, XST.
- Outputs are decoded from state only, plus latched op for XRD. There is no combinational path from z_flag to any output.
- Reset (async, any state): state=IDLE, instr_count=0.
  - In IDLE all strobes are 0, R_NW=1, alu_op=00.
  - IDLE -> F0 on the first clock after n_reset deasserts.
- F0: PC_bus, load_MAR, load_PC, INC_PC. MAR<=PC and PC<=PC+1 occur on the same edge. -> F1.
- F1: CS, R_NW, MDR_bus, load_IR. -> D0.
- D0: Addr_bus, load_MAR. The next state is chosen from op captured at the F1 edge:
  - LOAD/ADD/SUB/XOR -> XRD.
  - STORE -> XST.
  - BNE with z_flag=0 -> XRD.
  - BNE with z_flag=1 -> F0 (not taken).
  - NOP -> F0.
- XRD: CS, R_NW, MDR_bus. The op latched in D0 selects the action:
  - LOAD: load_ACC, alu_op=00.
  - ADD: load_ACC, alu_op=01.
  - SUB: load_ACC, alu_op=10.
  - XOR: load_ACC, alu_op=11.
  - BNE: load_PC with INC_PC=0. The branch is indirect: PC <= mem[operand].
  - XRD -> F0.
- XST: ACC_bus, load_MDR, CS, R_NW=0. Memory writes on the closing edge. -> F0.
- Bus exclusivity invariant: at most one of PC_bus, Addr_bus, ACC_bus, MDR_bus is 1 in every state.
- load_MDR is asserted only in XST. R_NW=0 only in XST.
- instr_count increments by 1 on every transition into F0 from D0, XRD or XST. It wraps from 2^CNT_W-1 to 0. It does not increment on IDLE->F0.
- z_flag is sampled only in D0. Changes elsewhere have no effect.
- Instruction latency, measured from F0 entry to the next F0 entry:
  - LOAD/ADD/SUB/XOR/STORE/taken BNE: 4 clocks.
  - Untaken BNE and NOP: 3 clocks.
- Reset asserted mid-instruction aborts it immediately. No partial strobe is held. Execution resumes at F0 with PC owned by the datapath reset.

Test Plan:
- Reset then release with op=000 -> IDLE for 1 cycle with all strobes 0, then F0 with PC_bus=load_MAR=load_PC=INC_PC=1; instr_count=0.
- op=010 (ADD), z_flag=x -> state sequence F0,F1,D0,XRD,F0; in XRD CS=R_NW=MDR_bus=load_ACC=1 and alu_op=01; instr_count 0->1.
- op=001 (STORE) -> XST has ACC_bus=load_MDR=CS=1 and R_NW=0; R_NW=1 in every other cycle.
- op=100 (BNE): z_flag=0 in D0 -> XRD with load_PC=1, INC_PC=0 (4 clocks); z_flag=1 -> D0 goes directly to F0 (3 clocks), no load_PC.
- op=110 run 256 instructions -> instr_count wraps 255->0; bus exclusivity assertion holds every cycle throughout.
- Pull n_reset low during XRD of a SUB -> all strobes drop combinationally to 0 and load_ACC never pulses; after release, IDLE then F0.
